prach_hb1_ps: RTL

//   Polyphase splitter that feeds the first half-band decimator channel stage.

---
 rtl/prach_hb1_ps_if.sv | 26 ++
 rtl/prach_hb1_ps.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/prach_hb1_ps_if.sv
// rtl/prach_hb1_ps_if.sv - sample-in / pair-out bundle of the half-band polyphase splitter
interface prach_hb1_ps_if #(
    parameter int WIDTH     = 16,
    parameter int CHN_WIDTH = 8
) ();
    logic [WIDTH-1:0]     din_dq;
    logic                 din_dv;
    logic [CHN_WIDTH-1:0] din_chn;
    logic                 sync_in;
    logic [WIDTH-1:0]     dout_dp1;
    logic [WIDTH-1:0]     dout_dp2;
    logic                 dout_dv;
    logic [CHN_WIDTH-1:0] dout_chn;
    logic                 sync_out;
    logic                 err_chn;

    modport master (
        output din_dq, din_dv, din_chn, sync_in,
        input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
    );

    modport slave (
        input  din_dq, din_dv, din_chn, sync_in,
        output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
    );
endinterface

// File: rtl/prach_hb1_ps.sv
// rtl/prach_hb1_ps.sv - per-channel even/odd pairing of a TDM stream for the first half-band stage
module prach_hb1_ps #(
    parameter int NUM_CHANNEL = 16,
    parameter int WIDTH       = 16,
    parameter int CHN_WIDTH   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    prach_hb1_ps_if.slave bus
);
    localparam int AW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;

    logic [WIDTH-1:0] ram [0:(2**AW)-1];

    logic [NUM_CHANNEL-1:0] phase_q, phase_d;
    logic                   pend_q, pend_d;
    logic                   err_q, err_d;
    logic                   legal;

    logic             s0_wr_q, s0_wr_d, s0_rd_q, s0_rd_d, s0_sync_q, s0_sync_d;
    logic [AW-1:0]    s0_addr_q, s0_addr_d;
    logic [WIDTH-1:0] s0_dq_q, s0_dq_d;

    logic             wr_vld_q, wr_vld_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_dq_q, wr_dq_d;

    logic             s1_vld_q, s1_vld_d, s1_sync_q, s1_sync_d;
    logic [AW-1:0]    s1_addr_q, s1_addr_d;
    logic [WIDTH-1:0] s1_dq_q, s1_dq_d, rd_q, rd_d;

    logic                 dv_q, dv_d, sync_q, sync_d;
    logic [WIDTH-1:0]     dp1_q, dp1_d, dp2_q, dp2_d;
    logic [CHN_WIDTH-1:0] chn_q, chn_d;

    // A sync clears every phase before the tagged sample itself is classified.
    always_comb begin
        phase_d   = phase_q;
        pend_d    = pend_q;
        err_d     = err_q;
        legal     = 1'b0;
        s0_wr_d   = 1'b0;
        s0_rd_d   = 1'b0;
        s0_sync_d = 1'b0;
        s0_addr_d = '0;
        s0_dq_d   = bus.din_dq;
        if (bus.din_dv) begin
            if (bus.sync_in) begin
                phase_d = '0;
                pend_d  = 1'b1;
            end
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                if (bus.din_chn == CHN_WIDTH'(i)) begin
                    legal     = 1'b1;
                    s0_addr_d = AW'(i);
                    if (phase_d[i]) begin
                        s0_rd_d   = 1'b1;
                        s0_sync_d = pend_q;
                        pend_d    = 1'b0;
                    end else begin
                        s0_wr_d = 1'b1;
                    end
                    phase_d[i] = ~phase_d[i];
                end
            end
            err_d = err_q | ~legal;
        end
    end

    // Forward the previous cycle's write so a RAM whose write lands late still reads write-first.
    always_comb begin
        wr_vld_d  = s0_wr_q;
        wr_addr_d = s0_addr_q;
        wr_dq_d   = s0_dq_q;
        rd_d      = (wr_vld_q && (wr_addr_q == s0_addr_q)) ? wr_dq_q : ram[s0_addr_q];
        s1_vld_d  = s0_rd_q;
        s1_sync_d = s0_rd_q & s0_sync_q;
        s1_addr_d = s0_addr_q;
        s1_dq_d   = s0_dq_q;
    end

    always_comb begin
        dv_d   = s1_vld_q;
        sync_d = s1_vld_q & s1_sync_q;
        dp1_d  = s1_vld_q ? rd_q : dp1_q;
        dp2_d  = s1_vld_q ? s1_dq_q : dp2_q;
        chn_d  = s1_vld_q ? CHN_WIDTH'(s1_addr_q) : chn_q;
    end

    always_ff @(posedge clk) begin
        if (s0_wr_q) begin
            ram[s0_addr_q] <= s0_dq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            s0_wr_q   <= 1'b0;
            s0_rd_q   <= 1'b0;
            s0_sync_q <= 1'b0;
            s0_addr_q <= '0;
            s0_dq_q   <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_dq_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_sync_q <= 1'b0;
            s1_addr_q <= '0;
            s1_dq_q   <= '0;
            rd_q      <= '0;
            dv_q      <= 1'b0;
            sync_q    <= 1'b0;
            dp1_q     <= '0;
            dp2_q     <= '0;
            chn_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            s0_wr_q   <= s0_wr_d;
            s0_rd_q   <= s0_rd_d;
            s0_sync_q <= s0_sync_d;
            s0_addr_q <= s0_addr_d;
            s0_dq_q   <= s0_dq_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_dq_q   <= wr_dq_d;
            s1_vld_q  <= s1_vld_d;
            s1_sync_q <= s1_sync_d;
            s1_addr_q <= s1_addr_d;
            s1_dq_q   <= s1_dq_d;
            rd_q      <= rd_d;
            dv_q      <= dv_d;
            sync_q    <= sync_d;
            dp1_q     <= dp1_d;
            dp2_q     <= dp2_d;
            chn_q     <= chn_d;
        end
    end

    assign bus.dout_dv  = dv_q;
    assign bus.sync_out = sync_q;
    assign bus.dout_dp1 = dp1_q;
    assign bus.dout_dp2 = dp2_q;
    assign bus.dout_chn = chn_q;
    assign bus.err_chn  = err_q;
endmodule
